// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths, ALU opcodes,
// forwarding-source select and the occupancy state of the stage.
package id_ex_stage_pkg;

    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_REG_ADDR_W = 5;
    localparam int DEFAULT_CTRL_W     = 4;

    localparam logic [DEFAULT_CTRL_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [DEFAULT_CTRL_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [DEFAULT_CTRL_W-1:0] ALU_MUL = 4'b0010;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side, forwarding and EX-side signals of the ID/EX stage.
// master = surrounding pipeline / bench, slave = the stage itself.
interface id_ex_stage_if #(
    parameter int DATA_W     = id_ex_stage_pkg::DEFAULT_DATA_W,
    parameter int REG_ADDR_W = id_ex_stage_pkg::DEFAULT_REG_ADDR_W,
    parameter int CTRL_W     = id_ex_stage_pkg::DEFAULT_CTRL_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  alu_src;
    logic [CTRL_W-1:0]     alu_control_in;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  flush;
    logic                  exmem_reg_write;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic [DATA_W-1:0]     exmem_result;
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic [DATA_W-1:0]     memwb_data;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_W-1:0]     data1;
    logic [DATA_W-1:0]     data2;
    logic [CTRL_W-1:0]     ALUControl;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] rd_out;
    logic                  reg_write_out;
    logic                  mem_read_out;
    logic                  mem_write_out;
    logic                  mem_to_reg_out;

    modport master (
        output in_valid, rs_data, rt_data, imm, rs_addr, rt_addr, rd_addr, alu_src,
               alu_control_in, reg_write, mem_read, mem_write, mem_to_reg, flush,
               exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd,
               memwb_data, out_ready,
        input  in_ready, out_valid, data1, data2, ALUControl, store_data, rd_out,
               reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out
    );

    modport slave (
        input  in_valid, rs_data, rt_data, imm, rs_addr, rt_addr, rd_addr, alu_src,
               alu_control_in, reg_write, mem_read, mem_write, mem_to_reg, flush,
               exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd,
               memwb_data, out_ready,
        output in_ready, out_valid, data1, data2, ALUControl, store_data, rd_out,
               reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out
    );
endinterface

// File: rtl/id_ex_stage_forward_mux.sv
// Operand forwarding for one source register: EX/MEM has priority over MEM/WB,
// and register 0 is never forwarded.
module id_ex_stage_forward_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0]     src_data,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_data,
    output logic [DATA_W-1:0]     fwd_data
);
    fwd_sel_e sel;

    always_comb begin
        sel = FWD_NONE;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == src_addr) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == src_addr) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        unique case (sel)
            FWD_EXMEM: fwd_data = exmem_result;
            FWD_MEMWB: fwd_data = memwb_data;
            default:   fwd_data = src_data;
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry valid/ready stage with operand forwarding,
// load-use bubble insertion, downstream stall and branch flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int CTRL_W     = DEFAULT_CTRL_W
) (
    input logic         clk,
    input logic         reset,
    id_ex_stage_if.slave bus
);
    state_e                state_q, state_d;
    logic                  vld_p1;
    logic [DATA_W-1:0]     rs_data_p1, rt_data_p1, imm_p1;
    logic [REG_ADDR_W-1:0] rs_addr_p1, rt_addr_p1, rd_p1;
    logic                  alu_src_p1;
    logic [CTRL_W-1:0]     alu_ctrl_p1;
    logic                  reg_write_p1, mem_read_p1, mem_write_p1, mem_to_reg_p1;
    logic [DATA_W-1:0]     fwd_rs, fwd_rt;
    logic                  advance, hazard, in_ready, accept;

    assign vld_p1   = (state_q == ST_FULL);
    assign advance  = !vld_p1 || bus.out_ready;
    assign hazard   = vld_p1 && mem_read_p1 && rd_p1 != '0 &&
                      (rd_p1 == bus.rs_addr || rd_p1 == bus.rt_addr);
    assign in_ready = advance && !hazard;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush)    state_d = ST_EMPTY;
        else if (accept)  state_d = ST_FULL;
        else if (advance) state_d = ST_EMPTY;
    end

    // ---- decode -> p1 register; held entries keep absorbing forwarded results ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_data_p1    <= '0;
            rt_data_p1    <= '0;
            imm_p1        <= '0;
            rs_addr_p1    <= '0;
            rt_addr_p1    <= '0;
            rd_p1         <= '0;
            alu_src_p1    <= 1'b0;
            alu_ctrl_p1   <= ALU_ADD;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
        end else if (bus.flush || (!accept && advance)) begin
            alu_ctrl_p1   <= ALU_ADD;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
        end else if (accept) begin
            rs_data_p1    <= bus.rs_data;
            rt_data_p1    <= bus.rt_data;
            imm_p1        <= bus.imm;
            rs_addr_p1    <= bus.rs_addr;
            rt_addr_p1    <= bus.rt_addr;
            rd_p1         <= bus.rd_addr;
            alu_src_p1    <= bus.alu_src;
            alu_ctrl_p1   <= bus.alu_control_in;
            reg_write_p1  <= bus.reg_write;
            mem_read_p1   <= bus.mem_read;
            mem_write_p1  <= bus.mem_write;
            mem_to_reg_p1 <= bus.mem_to_reg;
        end else begin
            rs_data_p1    <= fwd_rs;
            rt_data_p1    <= fwd_rt;
        end
    end

    id_ex_stage_forward_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
        .src_addr(rs_addr_p1), .src_data(rs_data_p1),
        .exmem_reg_write(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd),
        .exmem_result(bus.exmem_result), .memwb_reg_write(bus.memwb_reg_write),
        .memwb_rd(bus.memwb_rd), .memwb_data(bus.memwb_data), .fwd_data(fwd_rs)
    );

    id_ex_stage_forward_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
        .src_addr(rt_addr_p1), .src_data(rt_data_p1),
        .exmem_reg_write(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd),
        .exmem_result(bus.exmem_result), .memwb_reg_write(bus.memwb_reg_write),
        .memwb_rd(bus.memwb_rd), .memwb_data(bus.memwb_data), .fwd_data(fwd_rt)
    );

    // ---- p1 -> EX outputs ----
    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = vld_p1;
    assign bus.data1          = fwd_rs;
    assign bus.data2          = alu_src_p1 ? imm_p1 : fwd_rt;
    assign bus.store_data     = fwd_rt;
    assign bus.rd_out         = rd_p1;
    assign bus.ALUControl     = vld_p1 ? alu_ctrl_p1 : ALU_ADD;
    assign bus.reg_write_out  = vld_p1 && reg_write_p1;
    assign bus.mem_read_out   = vld_p1 && mem_read_p1;
    assign bus.mem_write_out  = vld_p1 && mem_write_p1;
    assign bus.mem_to_reg_out = vld_p1 && mem_to_reg_p1;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by random traffic,
// checked against a queue-based model of the one-entry stage.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    typedef struct {
        logic [31:0] rs_v, rt_v, imm;
        logic [4:0]  rs_a, rt_a, rd;
        logic        alu_src;
        logic [3:0]  ctrl;
        logic        rw, mr, mw, mtr;
    } inst_t;

    logic  clk = 1'b0;
    logic  reset;
    int    n_checks = 0;
    int    n_fail   = 0;
    inst_t q[$];

    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] v);
        if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == a) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == a) return bus.memwb_data;
        return v;
    endfunction

    task automatic set_idle();
        bus.in_valid = 0; bus.rs_data = 0; bus.rt_data = 0; bus.imm = 0;
        bus.rs_addr = 0; bus.rt_addr = 0; bus.rd_addr = 0; bus.alu_src = 0;
        bus.alu_control_in = ALU_ADD; bus.reg_write = 0; bus.mem_read = 0;
        bus.mem_write = 0; bus.mem_to_reg = 0; bus.flush = 0; bus.out_ready = 1;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
    endtask

    task automatic set_inst(input logic [4:0] rs_a, input logic [31:0] rs_v,
                            input logic [4:0] rt_a, input logic [31:0] rt_v,
                            input logic [4:0] rd, input logic alu_src, input logic [31:0] imm,
                            input logic [3:0] ctrl, input logic rw, input logic mr);
        bus.in_valid = 1; bus.rs_addr = rs_a; bus.rs_data = rs_v;
        bus.rt_addr = rt_a; bus.rt_data = rt_v; bus.rd_addr = rd;
        bus.alu_src = alu_src; bus.imm = imm; bus.alu_control_in = ctrl;
        bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = 0; bus.mem_to_reg = mr;
    endtask

    // Model the edge: decide from the current inputs, then update the queue after the edge.
    task automatic tick();
        inst_t nxt, held;
        bit mvalid, hz, rdy, do_clear, do_push, do_refresh;
        mvalid = (q.size() != 0);
        hz = 0;
        if (mvalid)
            hz = q[0].mr && q[0].rd != 5'd0 && (q[0].rd == bus.rs_addr || q[0].rd == bus.rt_addr);
        rdy = (!mvalid || bus.out_ready) && !hz;
        if (!reset) chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        do_clear   = reset || bus.flush;
        do_push    = !do_clear && bus.in_valid && rdy;
        do_refresh = !do_clear && !do_push && mvalid && !bus.out_ready;
        nxt.rs_v = bus.rs_data; nxt.rt_v = bus.rt_data; nxt.imm = bus.imm;
        nxt.rs_a = bus.rs_addr; nxt.rt_a = bus.rt_addr; nxt.rd = bus.rd_addr;
        nxt.alu_src = bus.alu_src; nxt.ctrl = bus.alu_control_in;
        nxt.rw = bus.reg_write; nxt.mr = bus.mem_read; nxt.mw = bus.mem_write; nxt.mtr = bus.mem_to_reg;
        if (mvalid) begin
            held = q[0];
            held.rs_v = ref_fwd(held.rs_a, held.rs_v);
            held.rt_v = ref_fwd(held.rt_a, held.rt_v);
        end
        @(posedge clk);
        #1;
        if (do_clear)        q.delete();
        else if (do_push)    q.push_back(nxt);
        else if (do_refresh) q[0] = held;
    endtask

    // Monitor: compares presented outputs with the model entry, pops on consumption.
    initial begin
        forever begin : mon
            bit ev;
            inst_t e;
            logic [31:0] e_rt;
            @(negedge clk);
            #4;
            if (!reset) begin
                ev = (q.size() != 0);
                chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
                if (ev && bus.out_valid) begin
                    e = q[0];
                    e_rt = ref_fwd(e.rt_a, e.rt_v);
                    chk("data1", bus.data1, ref_fwd(e.rs_a, e.rs_v));
                    chk("data2", bus.data2, e.alu_src ? e.imm : e_rt);
                    chk("store_data", bus.store_data, e_rt);
                    chk("ctrl", {19'd0, bus.ALUControl, bus.rd_out, bus.reg_write_out,
                                 bus.mem_read_out, bus.mem_write_out, bus.mem_to_reg_out},
                                {19'd0, e.ctrl, e.rd, e.rw, e.mr, e.mw, e.mtr});
                    if (bus.out_ready && !bus.flush) void'(q.pop_front());
                end else if (!bus.out_valid) begin
                    chk("ctrl_idle", {24'd0, bus.ALUControl, bus.reg_write_out, bus.mem_read_out,
                                      bus.mem_write_out, bus.mem_to_reg_out}, 32'd0);
                end
            end
        end
    end

    initial begin
        reset = 1;
        set_idle();
        repeat (2) begin @(negedge clk); #1; tick(); end
        @(negedge clk); reset = 0; #1; tick();

        // add r1(5), r2(7) with no forwarding
        @(negedge clk); set_inst(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 0, 32'd0, ALU_ADD, 1, 0); #1; tick();
        @(negedge clk); set_idle(); bus.out_ready = 0; #1;
        chk("t2_data1", bus.data1, 32'd5);
        chk("t2_data2", bus.data2, 32'd7);
        chk("t2_alu", {28'd0, bus.ALUControl}, 32'd0);
        chk("t2_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();

        // EX/MEM beats MEM/WB
        @(negedge clk); set_idle(); bus.out_ready = 0;
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd1; bus.exmem_result = 32'd9;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd1; bus.memwb_data = 32'd3; #1;
        chk("t3_exmem_prio", bus.data1, 32'd9);
        tick();
        @(negedge clk); set_idle(); #1; tick();
        // r0 is never forwarded
        @(negedge clk); set_inst(5'd0, 32'h55, 5'd2, 32'd1, 5'd3, 0, 32'd0, ALU_SUB, 1, 0); #1; tick();
        @(negedge clk); set_idle(); bus.out_ready = 0;
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd9; #1;
        chk("t3_r0", bus.data1, 32'h55);
        tick();
        @(negedge clk); set_idle(); #1; tick();

        // load-use: lw r4 then an instruction reading r4
        @(negedge clk); set_inst(5'd3, 32'd1, 5'd0, 32'd0, 5'd4, 1, 32'd8, ALU_ADD, 1, 1); #1; tick();
        @(negedge clk); set_inst(5'd4, 32'd2, 5'd5, 32'd3, 5'd6, 0, 32'd0, ALU_ADD, 1, 0); #1;
        chk("t4_stall", {31'd0, bus.in_ready}, 32'd0);
        tick();
        @(negedge clk); #1;
        chk("t4_bubble", {31'd0, bus.out_valid}, 32'd0);
        chk("t4_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        @(negedge clk); set_idle(); #1; tick();

        // stall 3 cycles; MEM/WB writes r2=11 only on the first
        @(negedge clk); set_inst(5'd1, 32'd1, 5'd2, 32'd7, 5'd3, 0, 32'd0, ALU_MUL, 1, 0); #1; tick();
        @(negedge clk); set_idle(); bus.out_ready = 0;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd2; bus.memwb_data = 32'd11; #1; tick();
        repeat (2) begin @(negedge clk); set_idle(); bus.out_ready = 0; #1; tick(); end
        @(negedge clk); set_idle(); #1;
        chk("t5_data2", bus.data2, 32'd11);
        tick();

        // flush while stalled with a new instruction offered
        @(negedge clk); set_inst(5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 0, 32'd0, ALU_ADD, 1, 0); #1; tick();
        @(negedge clk); set_inst(5'd5, 32'd6, 5'd6, 32'd7, 5'd7, 0, 32'd0, ALU_SUB, 1, 0);
        bus.out_ready = 0; bus.flush = 1; #1; tick();
        @(negedge clk); set_idle(); bus.out_ready = 0; #1;
        chk("t6_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rw", {31'd0, bus.reg_write_out}, 32'd0);
        tick();

        // random traffic, with a 2-cycle reset in the middle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.rs_addr = 5'($urandom_range(0, 7)); bus.rt_addr = 5'($urandom_range(0, 7));
            bus.rd_addr = 5'($urandom_range(0, 7));
            bus.rs_data = $urandom; bus.rt_data = $urandom; bus.imm = $urandom;
            bus.alu_src = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       bus.alu_control_in = ALU_ADD;
                1:       bus.alu_control_in = ALU_SUB;
                default: bus.alu_control_in = ALU_MUL;
            endcase
            bus.reg_write = 1'($urandom_range(0, 1)); bus.mem_read = 1'($urandom_range(0, 1));
            bus.mem_write = 1'($urandom_range(0, 1)); bus.mem_to_reg = 1'($urandom_range(0, 1));
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.exmem_reg_write = 1'($urandom_range(0, 1)); bus.exmem_rd = 5'($urandom_range(0, 7));
            bus.exmem_result = $urandom;
            bus.memwb_reg_write = 1'($urandom_range(0, 1)); bus.memwb_rd = 5'($urandom_range(0, 7));
            bus.memwb_data = $urandom;
            reset = (i == 200 || i == 201);
            #1;
            tick();
            if (i == 201) begin
                @(negedge clk); reset = 0; set_idle(); #1;
                chk("t1_valid", {31'd0, bus.out_valid}, 32'd0);
                chk("t1_alu", {28'd0, bus.ALUControl}, 32'd0);
                chk("t1_ready", {31'd0, bus.in_ready}, 32'd1);
                tick();
            end
        end

        @(negedge clk); set_idle(); #1; tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
